// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction, tagged with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_sync_fifo.sv
// Generic circular-buffer FIFO with occupancy count and single-cycle clear.
// Latency: a pushed word is visible at head_dat on the cycle after the push.
// Backpressure: none internal; caller must not push when full unless it pops in the same cycle.
module ifu_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_eff;
    logic             push_eff;

    // A pop on an empty queue is ignored; a push into a full queue only lands if a pop frees the slot.
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head_dat = mem[rd_ptr];

    // Storage array: written on every effective push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_eff && !pop_eff) begin
                count <= count + CW'(1);
            end else if (pop_eff && !push_eff) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Fetch front end: issues ROM reads, queues returned instructions with their PC, feeds Decode.
// Latency: ROM response in cycle N appears registered on o_pc/o_instr in N+1 when the queue is empty.
// Backpressure: i_stall freezes the output register; issue stops once queue+in-flight+output would exceed DEPTH+1.
module ifu_prefetch_queue
    import ifu_pkg::*;
#(
    parameter int              XLEN      = ifu_pkg::XLEN,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic            i_boj,
    input  logic [XLEN-1:0] i_boj_pc,
    input  logic            i_flush,
    input  logic            i_stall,
    output logic [XLEN-1:0] o_rom_addr,
    output logic            o_rom_addr_vld,
    input  logic            i_rom_rdy,
    input  logic [XLEN-1:0] i_rom_data,
    input  logic            i_rom_data_vld,
    output logic            o_fetch_rdy,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output logic            o_vld
);

    localparam int OW = $clog2(MAX_OUTST+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic [OW-1:0]   outst_nxt;
    logic            fetch_rdy_q;

    fetch_entry_t    push_ent;
    fetch_entry_t    head_ent;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_full;
    logic            q_push;
    logic            q_pop;

    logic            redirect;
    logic [XLEN-1:0] redir_pc;
    logic            rom_acc;
    logic            resp_take;
    logic            out_load;
    logic [SW-1:0]   occupancy;

    assign redirect  = i_trap | i_boj | i_flush;

    // Every slot a request could eventually need is counted before issuing, so the queue cannot overflow.
    assign occupancy = SW'(q_count) + SW'(outst) + SW'(o_vld);

    assign o_rom_addr_vld = fetch_rdy_q && !redirect
                         && (outst < OW'(MAX_OUTST))
                         && (occupancy < SW'(DEPTH + 1));
    assign o_rom_addr  = fetch_pc;
    assign o_fetch_rdy = fetch_rdy_q;

    assign rom_acc   = o_rom_addr_vld && i_rom_rdy;
    assign resp_take = i_rom_data_vld && (drop == '0);
    assign out_load  = !o_vld || !i_stall;
    assign outst_nxt = outst + OW'(rom_acc) - OW'(i_rom_data_vld);

    // Responses bypass the queue when it is empty and the output register is loading.
    assign q_pop    = out_load && !q_empty && !redirect;
    assign q_push   = resp_take && !(out_load && q_empty) && !redirect;
    assign push_ent = '{pc: resp_pc, instr: i_rom_data};

    // Redirect target: trap beats branch beats flush; flush replays the oldest undelivered PC.
    always_comb begin
        redir_pc = resp_pc;
        if (i_trap) begin
            redir_pc = {i_trap_pc[XLEN-1:2], 2'b00};
        end else if (i_boj) begin
            redir_pc = {i_boj_pc[XLEN-1:2], 2'b00};
        end else if (o_vld) begin
            redir_pc = o_pc;
        end else if (!q_empty) begin
            redir_pc = head_ent.pc;
        end
    end

    ifu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (q_push),
        .push_dat (push_ent),
        .pop      (q_pop),
        .head_dat (head_ent),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    // Fetch/response address tracking and in-flight bookkeeping; a redirect marks all in-flight replies stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outst       <= '0;
            drop        <= '0;
            fetch_rdy_q <= 1'b0;
        end else begin
            fetch_rdy_q <= 1'b1;
            outst       <= outst_nxt;
            if (redirect) begin
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
                drop     <= outst_nxt;
            end else begin
                if (rom_acc) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (resp_take) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (i_rom_data_vld && (drop != '0)) begin
                    drop <= drop - OW'(1);
                end
            end
        end
    end

    // Output register: holds under stall, otherwise takes queue head or a bypassed response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_vld   <= 1'b0;
            o_pc    <= '0;
            o_instr <= XLEN'(NOP_INSTR);
        end else if (redirect) begin
            o_vld <= 1'b0;
        end else if (out_load) begin
            if (!q_empty) begin
                o_vld   <= 1'b1;
                o_pc    <= head_ent.pc;
                o_instr <= head_ent.instr;
            end else if (resp_take) begin
                o_vld   <= 1'b1;
                o_pc    <= resp_pc;
                o_instr <= i_rom_data;
            end else begin
                o_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: behavioural ROM with variable latency, PC-sequence scoreboard.
// Latency: n/a.
// Backpressure: ROM ready optionally randomised; Decode stall driven per test.
module tb_ifu_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_trap = 1'b0;
    logic [31:0] i_trap_pc = '0;
    logic        i_boj = 1'b0;
    logic [31:0] i_boj_pc = '0;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic [31:0] o_rom_addr;
    logic        o_rom_addr_vld;
    logic        i_rom_rdy = 1'b1;
    logic [31:0] i_rom_data = '0;
    logic        i_rom_data_vld = 1'b0;
    logic        o_fetch_rdy;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_vld;

    ifu_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .i_trap         (i_trap),
        .i_trap_pc      (i_trap_pc),
        .i_boj          (i_boj),
        .i_boj_pc       (i_boj_pc),
        .i_flush        (i_flush),
        .i_stall        (i_stall),
        .o_rom_addr     (o_rom_addr),
        .o_rom_addr_vld (o_rom_addr_vld),
        .i_rom_rdy      (i_rom_rdy),
        .i_rom_data     (i_rom_data),
        .i_rom_data_vld (i_rom_data_vld),
        .o_fetch_rdy    (o_fetch_rdy),
        .o_pc           (o_pc),
        .o_instr        (o_instr),
        .o_vld          (o_vld)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int deliv = 0;
    bit rand_rdy    = 1'b0;
    bit chk_noissue = 1'b0;
    bit found;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rom_req_t;
    rom_req_t    rom_q[$];
    logic [31:0] exp_q[$];
    logic        acc;
    logic [31:0] acc_addr;

    typedef struct {
        logic        stall;
        logic        addr_vld;
        logic [31:0] addr;
        logic        fetch_rdy;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;
    vec_t vecs[6];

    // ROM contents: distinct word per address so stale data is recognisable.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_min(input string name, input int act, input int min);
        total++;
        if (act < min) begin
            bad++;
            $display("FAIL %s: got %0d want at least %0d", name, act, min);
        end
    endtask

    task automatic restart_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    // One clock: sample/check at negedge, then advance the ROM model just after posedge.
    task automatic tick(input int row);
        logic [31:0] e;
        @(negedge clk);
        if (row >= 0) begin
            chk("tbl_addr_vld",  32'(o_rom_addr_vld), 32'(vecs[row].addr_vld));
            chk("tbl_addr",      o_rom_addr,          vecs[row].addr);
            chk("tbl_fetch_rdy", 32'(o_fetch_rdy),    32'(vecs[row].fetch_rdy));
            chk("tbl_vld",       32'(o_vld),          32'(vecs[row].vld));
            chk("tbl_pc",        o_pc,                vecs[row].pc);
            chk("tbl_instr",     o_instr,             vecs[row].instr);
        end
        if (chk_noissue) begin
            chk("full_no_issue", 32'(o_rom_addr_vld), 32'd0);
        end
        if (i_trap || i_boj || i_flush) begin
            chk("redir_no_issue", 32'(o_rom_addr_vld), 32'd0);
        end
        if (!rst && o_vld && !i_flush) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got pc %h want nothing", o_pc);
            end else if (!i_stall) begin
                e = exp_q.pop_front();
                chk("sb_pc", o_pc, e);
                chk("sb_instr", o_instr, rom_word(e));
                deliv++;
            end else begin
                chk("stall_pc", o_pc, exp_q[0]);
                chk("stall_instr", o_instr, rom_word(exp_q[0]));
            end
        end
        acc      = o_rom_addr_vld && i_rom_rdy;
        acc_addr = o_rom_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            rom_q.delete();
            i_rom_data_vld = 1'b0;
        end else begin
            if (i_rom_data_vld && rom_q.size() > 0) begin
                rom_q.delete(0);
            end
            if (acc) begin
                rom_q.push_back('{acc_addr, cyc + lat - 1});
            end
            if (rom_q.size() > 0 && rom_q[0].due <= cyc) begin
                i_rom_data_vld = 1'b1;
                i_rom_data     = rom_word(rom_q[0].addr);
            end else begin
                i_rom_data_vld = 1'b0;
                i_rom_data     = $urandom;
            end
        end
        i_rom_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start-up stream, ROM always ready, one-cycle latency.
        vecs[0] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NOP};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, NOP};
        vecs[2] = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h0, NOP};
        vecs[3] = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 32'h0, rom_word(32'h0)};
        vecs[4] = '{1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 32'h4, rom_word(32'h4)};
        vecs[5] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h8, rom_word(32'h8)};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        restart_exp(32'h0);
        for (int r = 0; r < 6; r++) begin
            i_stall = vecs[r].stall;
            tick(r);
        end

        // Stall mid-stream: output frozen, queue fills, issue stops.
        repeat (4) tick(-1);
        for (int k = 0; k < 5; k++) begin
            i_stall     = 1'b1;
            chk_noissue = (k == 4);
            tick(-1);
        end
        chk_noissue = 1'b0;
        i_stall     = 1'b0;
        deliv       = 0;
        repeat (20) tick(-1);
        chk_min("stall_release_progress", deliv, 15);

        // Branch to an unaligned target while requests are in flight.
        lat = 3;
        repeat (12) tick(-1);
        i_boj    = 1'b1;
        i_boj_pc = 32'h103;
        tick(-1);
        i_boj = 1'b0;
        chk("boj_vld_cleared", 32'(o_vld), 32'd0);
        restart_exp(32'h100);
        deliv = 0;
        repeat (25) tick(-1);
        chk_min("boj_progress", deliv, 3);

        // Trap and branch together: trap target wins.
        i_trap    = 1'b1;
        i_trap_pc = 32'h80;
        i_boj     = 1'b1;
        i_boj_pc  = 32'h200;
        tick(-1);
        i_trap = 1'b0;
        i_boj  = 1'b0;
        chk("trap_vld_cleared", 32'(o_vld), 32'd0);
        restart_exp(32'h80);
        deliv = 0;
        repeat (25) tick(-1);
        chk_min("trap_progress", deliv, 3);

        // Flush while 0x24 is held at the output: it must be replayed.
        lat      = 1;
        i_boj    = 1'b1;
        i_boj_pc = 32'h10;
        tick(-1);
        i_boj = 1'b0;
        restart_exp(32'h10);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(-1);
            if (o_vld && o_pc == 32'h24) begin
                found   = 1'b1;
                i_stall = 1'b1;
            end
        end
        chk("flush_reach_0x24", 32'(found), 32'd1);
        repeat (2) tick(-1);
        i_flush = 1'b1;
        tick(-1);
        i_flush = 1'b0;
        i_stall = 1'b0;
        chk("flush_vld_cleared", 32'(o_vld), 32'd0);
        restart_exp(32'h24);
        deliv = 0;
        repeat (20) tick(-1);
        chk_min("flush_progress", deliv, 10);

        // Asynchronous reset mid-stream with slow, randomly ready ROM.
        lat      = 3;
        rand_rdy = 1'b1;
        repeat (30) tick(-1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_vld",       32'(o_vld),          32'd0);
        chk("rst_pc",        o_pc,                32'h0);
        chk("rst_instr",     o_instr,             NOP);
        chk("rst_addr_vld",  32'(o_rom_addr_vld), 32'd0);
        chk("rst_addr",      o_rom_addr,          32'h0);
        chk("rst_fetch_rdy", 32'(o_fetch_rdy),    32'd0);
        repeat (2) tick(-1);
        rst = 1'b0;
        restart_exp(32'h0);
        deliv = 0;
        repeat (200) tick(-1);
        chk_min("post_reset_progress", deliv, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
